// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: datapath width, writeback select codes,
// and the writeback multiplexer used to build the selected MEM/WB word.
package memory_stage_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_RSV = 2'd3
  } wb_sel_e;

  // Where the registered load word comes from: nothing, the RAM read port,
  // or a word captured at the edge (IO input or store data written through).
  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_RAM  = 2'd1,
    LD_HELD = 2'd2
  } ld_src_e;

  function automatic logic [DATA_W-1:0] wb_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] ld,
    input logic [DATA_W-1:0] pc
  );
    case (sel)
      WB_ALU:  return alu;
      WB_MEM:  return ld;
      WB_PC:   return pc;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Single-port data RAM: synchronous write and synchronous read on the same edge,
// with the written word returned on the read port (write-through).
module data_memory
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and its read register carry no reset so the RAM maps onto
  // block memory; reset suppression is applied to we by the caller instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 16-bit MISC-V pipeline: data RAM / memory-mapped IO access,
// IO output register and the MEM/WB pipeline register with writeback select.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int                ADDR_W  = 10,
  parameter logic [DATA_W-1:0] IO_ADDR = 16'hFFFE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IRegWrite,
  input  logic              IMemWrite,
  input  logic              IMemRead,
  input  logic [1:0]        IRegStore,
  input  logic [DATA_W-1:0] IPCP2,
  input  logic [DATA_W-1:0] IALUResult,
  input  logic [DATA_W-1:0] I3rdArg,
  input  logic [2:0]        IRd,
  input  logic [DATA_W-1:0] IIOIn,
  output logic [DATA_W-1:0] ALUResultMEM,
  output logic              ORegWrite,
  output logic [1:0]        ORegStore,
  output logic [DATA_W-1:0] OPCP2,
  output logic [DATA_W-1:0] OALUResult,
  output logic [DATA_W-1:0] OLoadData,
  output logic [DATA_W-1:0] OWriteData,
  output logic [2:0]        ORd,
  output logic              OMisaligned,
  output logic [DATA_W-1:0] OIOPort
);

  logic              io_sel;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  ld_src_e           ld_src_d, ld_src_q;
  logic [DATA_W-1:0] held_d, held_q;

  assign ALUResultMEM = IALUResult;
  assign io_sel       = (IALUResult == IO_ADDR);
  // Gating with reset keeps a store that lands on a reset edge out of the RAM.
  assign ram_we       = IMemWrite & ~io_sel & reset;

  data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
    .clk   (clk),
    .we    (ram_we),
    .addr  (IALUResult[ADDR_W:1]),
    .wdata (I3rdArg),
    .rdata (ram_rdata)
  );

  // NOTE: combinational blocks assign defaults first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    ld_src_d = LD_NONE;
    held_d   = IMemWrite ? I3rdArg : IIOIn;
    if (IMemRead) begin
      if (IMemWrite || io_sel) ld_src_d = LD_HELD;
      else                     ld_src_d = LD_RAM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they stood before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ORegWrite   <= 1'b0;
      ORegStore   <= WB_ALU;
      OPCP2       <= '0;
      OALUResult  <= '0;
      ORd         <= '0;
      OMisaligned <= 1'b0;
      ld_src_q    <= LD_NONE;
      held_q      <= '0;
      OIOPort     <= '0;
    end else begin
      ORegWrite   <= IRegWrite;
      ORegStore   <= IRegStore;
      OPCP2       <= IPCP2;
      OALUResult  <= IALUResult;
      ORd         <= IRd;
      OMisaligned <= (IMemRead | IMemWrite) & IALUResult[0];
      ld_src_q    <= ld_src_d;
      held_q      <= held_d;
      if (IMemWrite && io_sel) OIOPort <= I3rdArg;
    end
  end

  // Load and writeback words are pure functions of registered state, so they
  // change only at the edge and align with the rest of the MEM/WB bundle.
  always_comb begin
    OLoadData = '0;
    case (ld_src_q)
      LD_RAM:  OLoadData = ram_rdata;
      LD_HELD: OLoadData = held_q;
      default: OLoadData = '0;
    endcase
  end

  assign OWriteData = wb_mux(ORegStore, OALUResult, OLoadData, OPCP2);

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// traffic, compared against an array-based model of the data/IO address space.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRegWrite, IMemWrite, IMemRead;
  logic [1:0]  IRegStore;
  logic [15:0] IPCP2, IALUResult, I3rdArg, IIOIn;
  logic [2:0]  IRd;
  logic [15:0] ALUResultMEM, OPCP2, OALUResult, OLoadData, OWriteData, OIOPort;
  logic        ORegWrite, OMisaligned;
  logic [1:0]  ORegStore;
  logic [2:0]  ORd;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk          (clk),
    .reset        (reset),
    .IRegWrite    (IRegWrite),
    .IMemWrite    (IMemWrite),
    .IMemRead     (IMemRead),
    .IRegStore    (IRegStore),
    .IPCP2        (IPCP2),
    .IALUResult   (IALUResult),
    .I3rdArg      (I3rdArg),
    .IRd          (IRd),
    .IIOIn        (IIOIn),
    .ALUResultMEM (ALUResultMEM),
    .ORegWrite    (ORegWrite),
    .ORegStore    (ORegStore),
    .OPCP2        (OPCP2),
    .OALUResult   (OALUResult),
    .OLoadData    (OLoadData),
    .OWriteData   (OWriteData),
    .ORd          (ORd),
    .OMisaligned  (OMisaligned),
    .OIOPort      (OIOPort)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [15:0] pc;
    logic [15:0] alu;
    logic [15:0] ld;
    logic [15:0] wd;
    logic [2:0]  rd;
    logic        mis;
    logic [15:0] io;
  } exp_t;

  // Reference model: 1024-word RAM indexed by byte address / 2, plus IO word.
  logic [15:0] ram_m [1024];
  logic [15:0] io_m;
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".reg_write"},  {15'd0, ORegWrite},   {15'd0, e.rw});
    check({pfx, ".reg_store"},  {14'd0, ORegStore},   {14'd0, e.rs});
    check({pfx, ".pcp2"},       OPCP2,                e.pc);
    check({pfx, ".alu"},        OALUResult,           e.alu);
    check({pfx, ".load"},       OLoadData,            e.ld);
    check({pfx, ".write_data"}, OWriteData,           e.wd);
    check({pfx, ".rd"},         {13'd0, ORd},         {13'd0, e.rd});
    check({pfx, ".misaligned"}, {15'd0, OMisaligned}, {15'd0, e.mis});
    check({pfx, ".io_port"},    OIOPort,              e.io);
  endtask

  task automatic clear_model();
    e    = '{rw: 1'b0, rs: 2'd0, pc: 16'h0, alu: 16'h0, ld: 16'h0,
             wd: 16'h0, rd: 3'd0, mis: 1'b0, io: 16'h0};
    io_m = 16'h0;
  endtask

  // One MEM-stage transaction: drive, check the forwarding path, clock, check.
  task automatic step(input string tag, input logic rw, input logic w, input logic r,
                      input logic [1:0] rs, input logic [15:0] pc, input logic [15:0] alu,
                      input logic [15:0] d, input logic [2:0] rd, input logic [15:0] ioin);
    int          wa;
    logic        is_io;
    logic [15:0] ld;
    IRegWrite = rw; IMemWrite = w; IMemRead = r; IRegStore = rs;
    IPCP2 = pc; IALUResult = alu; I3rdArg = d; IRd = rd; IIOIn = ioin;
    #1;
    check({tag, ".fwd"}, ALUResultMEM, alu);
    wa    = (alu / 2) % 1024;
    is_io = (alu == 16'hFFFE);
    if (!r)        ld = 16'h0;
    else if (w)    ld = d;
    else if (is_io) ld = ioin;
    else           ld = ram_m[wa];
    @(posedge clk);
    if (reset) begin
      e.rw  = rw;
      e.rs  = rs;
      e.pc  = pc;
      e.alu = alu;
      e.ld  = ld;
      e.wd  = (rs == 2'd0) ? alu : (rs == 2'd1) ? ld : (rs == 2'd2) ? pc : 16'h0;
      e.rd  = rd;
      e.mis = (r || w) && alu[0];
      if (w) begin
        if (is_io) io_m = d;
        else       ram_m[wa] = d;
      end
      e.io = io_m;
    end else begin
      clear_model();
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [15:0] a, d;
    int          sel;
    reset = 1'b0;
    IRegWrite = 0; IMemWrite = 0; IMemRead = 0; IRegStore = 0;
    IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0; IIOIn = 0;
    clear_model();
    #3;
    check_outputs("reset_init");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Give every RAM word a known value so random loads have defined data.
    for (int i = 0; i < 1024; i++)
      step("fill", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'(i * 2), 16'($urandom), 3'd0, 16'h0);

    // Store then load back through the RAM.
    step("t2_store", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0010, 16'h1234, 3'd0, 16'h0);
    step("t2_load",  1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0010, 16'h0, 3'd3, 16'h0);
    check("t2_load_const", OWriteData, 16'h1234);
    check("t2_rd_const", {13'd0, ORd}, 16'd3);

    // Writeback select: PC+2, ALU, and the reserved code.
    step("t3_pc",  1'b1, 1'b0, 1'b0, 2'd2, 16'hA5A5, 16'h0100, 16'h0, 3'd1, 16'h0);
    check("t3_pc_const", OWriteData, 16'hA5A5);
    step("t3_alu", 1'b1, 1'b0, 1'b0, 2'd0, 16'hA5A5, 16'h0042, 16'h0, 3'd2, 16'h0);
    check("t3_alu_const", OWriteData, 16'h0042);
    step("t3_rsv", 1'b1, 1'b0, 1'b1, 2'd3, 16'hA5A5, 16'h0010, 16'h0, 3'd2, 16'h0);

    // IO store leaves the aliased RAM word alone; IO load returns IIOIn.
    step("t4_io_store", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'hFFFE, 16'hBEEF, 3'd0, 16'h0);
    check("t4_io_const", OIOPort, 16'hBEEF);
    step("t4_ram_3ff",  1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 16'h07FE, 16'h0, 3'd4, 16'h0);
    step("t4_io_load",  1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 16'hFFFE, 16'h0, 3'd4, 16'h00C3);
    check("t4_io_load_const", OLoadData, 16'h00C3);

    // Misaligned and aliased addresses, and read+write write-through.
    step("t5_odd",   1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0011, 16'h0, 3'd5, 16'h0);
    check("t5_odd_const", OLoadData, 16'h1234);
    step("t5_alias", 1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0810, 16'h0, 3'd5, 16'h0);
    check("t5_alias_const", OLoadData, 16'h1234);
    step("t5_wt",    1'b1, 1'b1, 1'b1, 2'd1, 16'h0, 16'h0020, 16'h7E57, 3'd6, 16'h0);

    // Asynchronous reset mid-cycle, then a store lost on a reset edge.
    reset = 1'b0;
    clear_model();
    #1;
    check_outputs("t1_async_reset");
    step("t6_lost_store", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0010, 16'h5555, 3'd0, 16'h0);
    reset = 1'b1;
    step("t6_load", 1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0010, 16'h0, 3'd3, 16'h0);
    check("t6_load_const", OLoadData, 16'h1234);

    // Random traffic biased towards a small window and the IO address.
    for (int i = 0; i < 500; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 16'hFFFE;
      else if (sel < 5)  a = 16'($urandom_range(0, 63));
      else               a = 16'($urandom);
      d = 16'($urandom);
      step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
           16'($urandom), a, d, 3'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
